alarm_bank_ctrl: RTL

Parametrised successor to the weekday alarm register set. It holds N alarm-time entries, each with its own armed bit. On every minute tick it compares the current time against the entry for the current day. A ring/snooze state machine then drives the alarm output. It sits between the time-keeping counter and the buzzer/display logic.

---
 rtl/alarm_bank_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/alarm_bank_ctrl.sv
// alarm_bank_ctrl: N-entry alarm time bank with per-entry arm bits, minute-tick matching and a ring/snooze FSM.
// Optional build macro ALARM_ONESHOT_EN: dismissal or ring timeout also disarms the triggering entry.
module alarm_bank_ctrl #(
    parameter int N          = 7,
    parameter int W          = 13,
    parameter int AW         = 3,
    parameter int SNOOZE_MIN = 9,
    parameter int RING_MAX   = 5
) (
    input  logic          Clk,
    input  logic          Clr,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          arm_set,
    input  logic          arm_clr,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data,
    output logic [N-1:0]  armed,
    input  logic [AW-1:0] day,
    input  logic [W-1:0]  now,
    input  logic          tick,
    input  logic          ack,
    input  logic          snooze,
    output logic          ring,
    output logic          snoozing,
    output logic [AW-1:0] ring_day
);

    if (N < 1 || (2 ** AW) < N || W < 1 || SNOOZE_MIN < 1 || SNOOZE_MIN > 255 ||
        RING_MAX < 1 || RING_MAX > 255) begin : g_bad_params
        $error("alarm_bank_ctrl: parameter out of range");
    end

    localparam logic [AW:0] N_L       = (AW + 1)'(N);
    localparam logic [7:0]  RING_LAST = 8'(RING_MAX - 1);
    localparam logic [7:0]  SNZ_INIT  = 8'(SNOOZE_MIN);

    typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

    state_t         state;
    logic [W-1:0]   entries [N];
    logic [7:0]     ring_cnt;
    logic [7:0]     snz_cnt;
    logic           wr_ok;
    logic           rd_ok;
    logic           day_ok;
    logic           match;

    assign wr_ok  = {1'b0, wr_addr} < N_L;
    assign rd_ok  = {1'b0, rd_addr} < N_L;
    assign day_ok = {1'b0, day} < N_L;

    // A match looks at the entry contents before this edge, so a same-cycle write is not seen.
    always_comb begin
        match = 1'b0;
        if (tick && day_ok && armed[day] && entries[day] == now)
            match = 1'b1;
    end

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            for (int i = 0; i < N; i++)
                entries[i] <= '0;
            rd_data <= '0;
        end else begin
            if (wr_en && wr_ok)
                entries[wr_addr] <= wr_data;
            rd_data <= rd_ok ? entries[rd_addr] : '0;
        end
    end

`ifdef ALARM_ONESHOT_EN
    logic oneshot_clr;

    // Any dismissal (ack or unanswered timeout) retires a one-shot alarm.
    always_comb begin
        oneshot_clr = 1'b0;
        if (state == RING && (ack || (!snooze && tick && ring_cnt == RING_LAST)))
            oneshot_clr = 1'b1;
        if (state == SNOOZE && ack)
            oneshot_clr = 1'b1;
    end
`endif

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            armed <= '0;
        end else begin
            if (wr_ok) begin
                if (arm_clr)
                    armed[wr_addr] <= 1'b0;
                else if (arm_set)
                    armed[wr_addr] <= 1'b1;
            end
`ifdef ALARM_ONESHOT_EN
            if (oneshot_clr)
                armed[ring_day] <= 1'b0;
`endif
        end
    end

    // Losing the arm bit of the ringing entry cancels the alarm on the following edge.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state    <= IDLE;
            ring     <= 1'b0;
            snoozing <= 1'b0;
            ring_day <= '0;
            ring_cnt <= '0;
            snz_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (match) begin
                        state    <= RING;
                        ring     <= 1'b1;
                        ring_day <= day;
                        ring_cnt <= '0;
                    end
                end
                RING: begin
                    if (ack || !armed[ring_day]) begin
                        state <= IDLE;
                        ring  <= 1'b0;
                    end else if (snooze) begin
                        state    <= SNOOZE;
                        ring     <= 1'b0;
                        snoozing <= 1'b1;
                        snz_cnt  <= SNZ_INIT;
                    end else if (tick) begin
                        if (ring_cnt == RING_LAST) begin
                            state <= IDLE;
                            ring  <= 1'b0;
                        end else begin
                            ring_cnt <= ring_cnt + 8'd1;
                        end
                    end
                end
                SNOOZE: begin
                    if (ack || !armed[ring_day]) begin
                        state    <= IDLE;
                        snoozing <= 1'b0;
                    end else if (tick) begin
                        if (snz_cnt == 8'd1) begin
                            state    <= RING;
                            ring     <= 1'b1;
                            snoozing <= 1'b0;
                            ring_cnt <= '0;
                        end else begin
                            snz_cnt <= snz_cnt - 8'd1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    ring     <= 1'b0;
                    snoozing <= 1'b0;
                end
            endcase
        end
    end

endmodule
